scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL have parameter W, default 4: data width per channel.
REQ-002 The block SHALL have parameter N, default 8: channel count, range 2..16.
REQ-003 The block SHALL have parameter DWELL, default 4: cycles per channel in auto mode, minimum 1.
REQ-004 The block SHALL derive SW = $clog2(N): select and index width.
REQ-005 The block SHALL have port clk, input, 1: single clock; all logic SHALL be on the rising edge.
REQ-006 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port d, input, N*W: packed channel data; channel k occupies bits [k*W +: W].
REQ-008 The block SHALL have port sel, input, SW: manual channel select.
REQ-009 The block SHALL have port mode, input, 1: 0 = manual, 1 = auto-scan.
REQ-010 The block SHALL have port en_mask, input, N: per-channel enable for auto-scan.
REQ-011 The block SHALL have port hold, input, 1: freezes the auto-scan dwell counter and channel.
REQ-012 The block SHALL have port y, output, W: registered selected data.
REQ-013 The block SHALL have port ch, output, SW: registered index of the channel driving y.
REQ-014 The block SHALL have port valid, output, 1: y/ch are meaningful.
REQ-015 The block SHALL have port adv, output, 1: one-cycle pulse, registered, on each auto-scan channel advance.

Function
REQ-016 y, ch, valid and adv SHALL be registered; y SHALL equal d[ch] as sampled on the same edge that loads ch (1-cycle latency from d/sel).
REQ-017 The FSM SHALL have states MANUAL, IDLE and SCAN; after reset the state SHALL be MANUAL when mode=0 and IDLE when mode=1, evaluated on the first edge after reset is released.
REQ-018 MANUAL: each cycle, ch<=sel, y<=d[sel], valid<=1; if sel>=N (N not a power of 2), y<=0 and valid<=0.
REQ-019 mode 0->1 SHALL enter SCAN starting at the current ch if en_mask[ch]=1, otherwise at the next enabled channel above ch with wrap-around; the dwell counter SHALL clear to 0.
REQ-020 mode 1->0 SHALL enter MANUAL on the next edge; adv SHALL be 0 in that cycle.
REQ-021 SCAN: the counter SHALL increment each cycle with hold=0; at DWELL-1 it SHALL clear, ch SHALL advance to the next enabled channel (N-1 wraps to 0), and adv SHALL pulse for 1 cycle.
REQ-022 SCAN with only one enabled channel: the advance SHALL reselect the same channel and adv SHALL still pulse.
REQ-023 SCAN, hold=1: the counter and ch SHALL freeze, y SHALL keep tracking d[ch], and adv SHALL be 0; hold SHALL be ignored in MANUAL.
REQ-024 en_mask==0 with mode=1: the FSM SHALL go to IDLE with y<=0, valid<=0, ch held; IDLE->SCAN SHALL occur when any bit is set, at the first enabled channel at or after ch.
REQ-025 If en_mask[ch] is cleared during SCAN, the block SHALL advance immediately on the next edge (counter cleared, adv pulsed), regardless of hold.
REQ-026 valid SHALL be 1 in SCAN.

Reset
REQ-027 While reset=1 at a rising edge: y=0, ch=0, valid=0, adv=0, counter=0, state=IDLE; reset asserted mid-scan SHALL abort the scan with no adv pulse.

Structure
REQ-028 Package scan_mux_pkg SHALL hold the state enum (MANUAL, IDLE, SCAN) and default parameter constants.
REQ-029 Sub-module next_enabled_ch SHALL compute, combinationally, the next set bit of en_mask strictly after (and, with a flag, at or after) a given index, with wrap-around and an any-set output.

Verification (N=8, W=4, DWELL=4)
REQ-030 Manual: d[k]=k+1, mode=0, sel=5 -> next cycle y=6, ch=5, valid=1, adv=0.
REQ-031 Auto: en_mask=8'hFF, mode=1 -> ch steps 0,1,...,7,0 every 4 cycles with one adv pulse per step.
REQ-032 Skip: en_mask=8'b1000_0101 -> ch sequence 0,2,7,0; y equals the matching d values.
REQ-033 Hold: assert hold for 6 cycles in dwell cycle 2 -> ch unchanged, no adv, advance 2 cycles after hold drops.
REQ-034 Edge: en_mask->0 during SCAN -> valid=0, y=0 next cycle; en_mask=8'h10 -> SCAN at ch=4.
REQ-035 Reset mid-scan at ch=3, counter=2 -> all outputs 0, no adv pulse.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared FSM state type and default parameter values for scan_mux.
//   state_e  : MANUAL (sel drives output), IDLE (auto mode, nothing enabled), SCAN (auto-scan)
//   DefW/DefN/DefDwell : default data width, channel count and dwell length
package scan_mux_pkg;

   localparam int DefW     = 4;
   localparam int DefN     = 8;
   localparam int DefDwell = 4;

   typedef enum logic [1:0] {
      MANUAL,
      IDLE,
      SCAN
   } state_e;

endpackage

// File: rtl/next_enabled_ch.sv
// next_enabled_ch: combinational search for the next set bit of a channel mask.
//   mask : per-channel enable bits
//   idx  : starting channel index
//   incl : 1 = search at or after idx, 0 = strictly after idx (idx itself is the last candidate)
//   nxt  : first enabled channel found, wrapping N-1 -> 0; idx when mask is empty
//   any  : at least one mask bit is set
module next_enabled_ch #(
   parameter  int N  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  mask,
   input  logic [SW-1:0] idx,
   input  logic          incl,
   output logic [SW-1:0] nxt,
   output logic          any
);

   logic [SW-1:0] pos;

   // Walk offsets from farthest to nearest so the closest hit wins. Offset N lands back
   // on idx, which lets a lone enabled channel reselect itself in strict mode.
   always_comb begin
      nxt = idx;
      pos = '0;
      for (int o = N; o >= 0; o--) begin
         pos = SW'((32'(idx) + 32'(o)) % 32'(N));
         if ((o > 0 || incl) && mask[pos]) begin
            nxt = pos;
         end
      end
   end

   assign any = |mask;

endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N:1 channel multiplexer with manual select and auto-scan.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   d          : packed channel data, channel k at [k*W +: W]
//   sel        : manual channel select (mode = 0)
//   mode       : 0 = manual, 1 = auto-scan over channels enabled in en_mask
//   en_mask    : per-channel auto-scan enable
//   hold       : freezes dwell counter and channel while scanning
//   y, ch      : registered data and index of the selected channel
//   valid      : y/ch are meaningful
//   adv        : one-cycle pulse on every auto-scan advance
module scan_mux
   import scan_mux_pkg::*;
#(
   parameter  int W     = DefW,
   parameter  int N     = DefN,
   parameter  int DWELL = DefDwell,
   localparam int SW    = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N*W-1:0] d,
   input  logic [SW-1:0]  sel,
   input  logic           mode,
   input  logic [N-1:0]   en_mask,
   input  logic           hold,
   output logic [W-1:0]   y,
   output logic [SW-1:0]  ch,
   output logic           valid,
   output logic           adv
);

   localparam int            CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CntMax = CW'(DWELL - 1);
   localparam logic [SW:0]   NumCh  = N[SW:0];

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] ch_d;
   logic [W-1:0]  y_d;
   logic          valid_d, adv_d;

   logic [W-1:0]  d_arr [N];
   logic [SW-1:0] nxt_ch;
   logic          any_en;
   logic          sel_ok;

   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign d_arr[k] = d[k*W +: W];
   end

   assign sel_ok = ({1'b0, sel} < NumCh);

   // Entering SCAN may start on the current channel; advancing within SCAN must move past it.
   next_enabled_ch #(
      .N (N)
   ) u_next (
      .mask (en_mask),
      .idx  (ch),
      .incl (state_q != SCAN),
      .nxt  (nxt_ch),
      .any  (any_en)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch;
      y_d     = '0;
      valid_d = 1'b0;
      adv_d   = 1'b0;
      if (!mode) begin
         state_d = MANUAL;
         cnt_d   = '0;
         ch_d    = sel;
         if (sel_ok) begin
            y_d     = d_arr[sel];
            valid_d = 1'b1;
         end
      end else if (!any_en) begin
         // Nothing to scan: park with output blanked, channel kept as the restart point.
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         state_d = SCAN;
         valid_d = 1'b1;
         unique case (state_q)
            MANUAL, IDLE: begin
               ch_d  = nxt_ch;
               cnt_d = '0;
            end
            SCAN: begin
               // A disabled current channel forces an advance even under hold.
               if (!en_mask[ch] || (!hold && cnt_q == CntMax)) begin
                  ch_d  = nxt_ch;
                  cnt_d = '0;
                  adv_d = 1'b1;
               end else if (!hold) begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
         y_d = d_arr[ch_d];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ch      <= '0;
         y       <= '0;
         valid   <= 1'b0;
         adv     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch      <= ch_d;
         y       <= y_d;
         valid   <= valid_d;
         adv     <= adv_d;
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

   localparam int W     = 4;
   localparam int N     = 8;
   localparam int DWELL = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [N*W-1:0] d;
   logic [2:0]     sel;
   logic           mode;
   logic [N-1:0]   en_mask;
   logic           hold;
   logic [W-1:0]   y;
   logic [2:0]     ch;
   logic           valid;
   logic           adv;

   int tests = 0;
   int fails = 0;

   scan_mux #(
      .W     (W),
      .N     (N),
      .DWELL (DWELL)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .d       (d),
      .sel     (sel),
      .mode    (mode),
      .en_mask (en_mask),
      .hold    (hold),
      .y       (y),
      .ch      (ch),
      .valid   (valid),
      .adv     (adv)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic m, input logic [N-1:0] mask);
      mode    = m;
      en_mask = mask;
      hold    = 1'b0;
      sel     = '0;
      reset   = 1'b1;
      step();
      step();
      reset   = 1'b0;
   endtask

   task automatic load_default_data();
      for (int k = 0; k < N; k++) d[k*W +: W] = 4'(k + 1);
   endtask

   task automatic test_reset();
      load_default_data();
      mode = 1'b0; sel = 3'd5; en_mask = 8'hFF; hold = 1'b0; reset = 1'b1;
      step();
      step();
      tests++;
      if ({y, ch, valid, adv} !== 9'b0) begin
         fails++;
         $display("FAIL reset_state: got y=%h ch=%0d valid=%b adv=%b want all 0", y, ch, valid, adv);
      end
      reset = 1'b0;
   endtask

   task automatic test_manual();
      load_default_data();
      do_reset(1'b0, 8'h00);
      sel = 3'd5;
      step();
      tests++;
      if ({y, ch, valid, adv} !== {4'd6, 3'd5, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL manual_sel5: got %h want %h", {y, ch, valid, adv}, {4'd6, 3'd5, 1'b1, 1'b0});
      end
      sel = 3'd0;
      step();
      tests++;
      if ({y, ch, valid} !== {4'd1, 3'd0, 1'b1}) begin
         fails++;
         $display("FAIL manual_sel0: got %h want %h", {y, ch, valid}, {4'd1, 3'd0, 1'b1});
      end
      sel = 3'd7; hold = 1'b1;
      step();
      tests++;
      if ({y, ch, valid, adv} !== {4'd8, 3'd7, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL manual_hold_ignored: got %h want %h", {y, ch, valid, adv},
                  {4'd8, 3'd7, 1'b1, 1'b0});
      end
      d[7*W +: W] = 4'hA;
      step();
      tests++;
      if (y !== 4'hA) begin
         fails++;
         $display("FAIL manual_track_d: got y=%h want y=a", y);
      end
      hold = 1'b0;
      load_default_data();
   endtask

   task automatic test_auto();
      load_default_data();
      do_reset(1'b1, 8'hFF);
      step();
      tests++;
      if ({y, ch, valid, adv} !== {4'd1, 3'd0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL auto_start: got %h want %h", {y, ch, valid, adv}, {4'd1, 3'd0, 1'b1, 1'b0});
      end
      for (int k = 1; k <= N; k++) begin
         for (int c = 0; c < DWELL - 1; c++) begin
            step();
            tests++;
            if ({ch, adv} !== {3'(k - 1), 1'b0}) begin
               fails++;
               $display("FAIL auto_dwell[%0d]: got ch=%0d adv=%b want ch=%0d adv=0", k, ch, adv, k - 1);
            end
         end
         step();
         tests++;
         if ({y, ch, valid, adv} !== {4'((k % N) + 1), 3'(k % N), 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL auto_step[%0d]: got %h want %h", k, {y, ch, valid, adv},
                     {4'((k % N) + 1), 3'(k % N), 1'b1, 1'b1});
         end
      end
   endtask

   task automatic test_skip();
      logic [2:0] exp_ch [4];
      exp_ch[0] = 3'd0; exp_ch[1] = 3'd2; exp_ch[2] = 3'd7; exp_ch[3] = 3'd0;
      load_default_data();
      do_reset(1'b1, 8'b1000_0101);
      step();
      tests++;
      if ({y, ch, adv} !== {4'd1, 3'd0, 1'b0}) begin
         fails++;
         $display("FAIL skip_start: got %h want %h", {y, ch, adv}, {4'd1, 3'd0, 1'b0});
      end
      for (int s = 1; s < 4; s++) begin
         repeat (DWELL) step();
         tests++;
         if ({y, ch, valid, adv} !== {4'(exp_ch[s]) + 4'd1, exp_ch[s], 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL skip_seq[%0d]: got %h want %h", s, {y, ch, valid, adv},
                     {4'(exp_ch[s]) + 4'd1, exp_ch[s], 1'b1, 1'b1});
         end
      end
   endtask

   task automatic test_hold();
      load_default_data();
      do_reset(1'b1, 8'hFF);
      step();   // SCAN at ch 0, count 0
      step();   // count 1
      step();   // count 2
      hold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) d[0 +: W] = 4'hC;
         step();
         tests++;
         if ({ch, valid, adv} !== {3'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL hold_freeze[%0d]: got ch=%0d valid=%b adv=%b want ch=0 valid=1 adv=0",
                     i, ch, valid, adv);
         end
      end
      tests++;
      if (y !== 4'hC) begin
         fails++;
         $display("FAIL hold_track_d: got y=%h want y=c", y);
      end
      hold = 1'b0;
      step();
      tests++;
      if ({ch, adv} !== {3'd0, 1'b0}) begin
         fails++;
         $display("FAIL hold_release1: got ch=%0d adv=%b want ch=0 adv=0", ch, adv);
      end
      step();
      tests++;
      if ({y, ch, adv} !== {4'd2, 3'd1, 1'b1}) begin
         fails++;
         $display("FAIL hold_release2: got %h want %h", {y, ch, adv}, {4'd2, 3'd1, 1'b1});
      end
      load_default_data();
   endtask

   task automatic test_edge();
      load_default_data();
      do_reset(1'b1, 8'hFF);
      step();
      step();
      step();   // ch 0, count 2
      en_mask = 8'h00;
      step();
      tests++;
      if ({y, ch, valid, adv} !== {4'd0, 3'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL edge_mask_empty: got %h want %h", {y, ch, valid, adv}, {4'd0, 3'd0, 1'b0, 1'b0});
      end
      en_mask = 8'h10;
      step();
      tests++;
      if ({y, ch, valid, adv} !== {4'd5, 3'd4, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL edge_restart_ch4: got %h want %h", {y, ch, valid, adv}, {4'd5, 3'd4, 1'b1, 1'b0});
      end
      repeat (DWELL - 1) step();
      tests++;
      if ({ch, adv} !== {3'd4, 1'b0}) begin
         fails++;
         $display("FAIL edge_single_dwell: got ch=%0d adv=%b want ch=4 adv=0", ch, adv);
      end
      step();
      tests++;
      if ({ch, valid, adv} !== {3'd4, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL edge_single_adv: got ch=%0d valid=%b adv=%b want ch=4 valid=1 adv=1",
                  ch, valid, adv);
      end
      en_mask = 8'h30;
      step();
      en_mask = 8'h20; hold = 1'b1;
      step();
      tests++;
      if ({y, ch, valid, adv} !== {4'd6, 3'd5, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL edge_cur_disabled: got %h want %h", {y, ch, valid, adv}, {4'd6, 3'd5, 1'b1, 1'b1});
      end
      hold = 1'b0; mode = 1'b0; sel = 3'd2;
      step();
      tests++;
      if ({y, ch, valid, adv} !== {4'd3, 3'd2, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL edge_to_manual: got %h want %h", {y, ch, valid, adv}, {4'd3, 3'd2, 1'b1, 1'b0});
      end
      en_mask = 8'h08; mode = 1'b1;
      step();
      tests++;
      if ({y, ch, valid, adv} !== {4'd4, 3'd3, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL edge_to_scan: got %h want %h", {y, ch, valid, adv}, {4'd4, 3'd3, 1'b1, 1'b0});
      end
   endtask

   task automatic test_reset_mid_scan();
      load_default_data();
      do_reset(1'b1, 8'hFF);
      step();
      repeat (3 * DWELL + 2) step();   // ch 3, count 2
      tests++;
      if ({ch, valid} !== {3'd3, 1'b1}) begin
         fails++;
         $display("FAIL midscan_setup: got ch=%0d valid=%b want ch=3 valid=1", ch, valid);
      end
      reset = 1'b1;
      step();
      tests++;
      if ({y, ch, valid, adv} !== 9'b0) begin
         fails++;
         $display("FAIL midscan_reset: got y=%h ch=%0d valid=%b adv=%b want all 0", y, ch, valid, adv);
      end
      step();
      tests++;
      if ({y, ch, valid, adv} !== 9'b0) begin
         fails++;
         $display("FAIL midscan_reset_hold: got y=%h ch=%0d valid=%b adv=%b want all 0",
                  y, ch, valid, adv);
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mode = 1'b0; sel = '0; en_mask = '0; hold = 1'b0; d = '0;
      test_reset();
      test_manual();
      test_auto();
      test_skip();
      test_hold();
      test_edge();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
